// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Data-memory bus between the load/store unit and the data memory.
//   The master (the load/store unit) raises bus_req. While bus_req is high it
//   holds bus_we, bus_addr, bus_be and bus_wdata stable. The slave (the memory)
//   completes the transfer with a one-cycle bus_ack. For reads, bus_rdata must
//   be valid in the same cycle as bus_ack.
//
// Signals
//   bus_req    master -> slave  transfer request
//   bus_we     master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  word-aligned byte address
//   bus_be     master -> slave  byte-lane enables
//   bus_wdata  master -> slave  lane-replicated store data
//   bus_ack    slave -> master  transfer complete
//   bus_rdata  slave -> master  read word, valid with bus_ack
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  bus_req;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory stage that follows the execute ALU. It accepts one load or store at
//   a time and runs it as a req/ack transaction on the data-memory bus. It then
//   returns aligned, sign- or zero-extended load data to writeback as a
//   one-cycle pulse.
//
//   Misaligned or illegal accesses are never issued on the bus. They complete
//   in the cycle after accept with wb_err set.
//
//   The byte/halfword/word lane rules assume DATA_WIDTH = 32.
//
// Optional feature
//   LSU_TIMEOUT_EN  Abandon a request after MAX_WAIT cycles in REQ with no
//                   bus_ack, and report wb_err. If bus_ack arrives on the
//                   expiry edge, the access completes normally.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   ex_valid/ready  operation handshake from the execute stage
//   mem_read/write  operation is a load / store
//   funct3          RISC-V access size and signedness
//   addr, wdata     effective address and store data
//   wb_valid        one-cycle completion pulse
//   wb_data         extended load data (0 for stores and errors)
//   wb_err          access error, qualified by wb_valid
//   bus             data-memory bus (master side)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_err,
  load_store_unit_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  accept;
  logic                  acc_err;
  logic [3:0]            be_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_ext;

  logic                  ex_ready_q;
  logic                  is_load_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic                  wb_err_q;

  assign accept = ex_valid & ex_ready_q & (mem_read | mem_write);

  // Legality of the presented operation; only meaningful when accept is high.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    acc_err = 1'b0;
    if (mem_read && mem_write) begin
      acc_err = 1'b1;
    end else if (mem_read) begin
      acc_err = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      acc_err = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end
    if (funct3[1:0] == 2'b01 && addr[0]) acc_err = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) acc_err = 1'b1;
  end

  // Byte enables and store data replicated into every lane the size covers.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {addr[1], 1'b0};
        wdata_nxt = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Move the addressed byte/half down to bit 0, then extend it. funct3[2]
  // selects zero extension (LBU/LHU).
  always_comb begin
    lane     = bus.bus_rdata >> {offset_q, 3'b000};
    load_ext = lane;
    case (funct3_q[1:0])
      2'b00:   load_ext = {{(DATA_WIDTH-8){~funct3_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{(DATA_WIDTH-16){~funct3_q[2] & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // The count is held at zero outside REQ, so every request starts from zero.
  assign timeout = (state == REQ) && (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != REQ) begin
      wait_cnt <= '0;
    end else if (!bus.bus_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = acc_err ? RESP : REQ;
`ifdef LSU_TIMEOUT_EN
      REQ:  if (bus.bus_ack || timeout) state_nxt = RESP;
`else
      REQ:  if (bus.bus_ack) state_nxt = RESP;
`endif
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the edge.
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ready_q <= 1'b0;
      is_load_q  <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      // Ready is high on every edge that lands in IDLE. Accepting leaves IDLE,
      // which clears it.
      ex_ready_q <= (state_nxt == IDLE);
      case (state)
        IDLE: if (accept) begin
          is_load_q <= mem_read;
          funct3_q  <= funct3;
          offset_q  <= addr[1:0];
          wb_err_q  <= acc_err;
          wb_data_q <= '0;
          // The bus fields are only updated for accesses that will be issued.
          if (!acc_err) begin
            we_q    <= mem_write;
            addr_q  <= {addr[DATA_WIDTH-1:2], 2'b00};
            be_q    <= be_nxt;
            wdata_q <= wdata_nxt;
          end
        end
        REQ: if (bus.bus_ack) begin
          wb_err_q  <= 1'b0;
          wb_data_q <= is_load_q ? load_ext : '0;
        end
`ifdef LSU_TIMEOUT_EN
        else if (timeout) begin
          wb_err_q  <= 1'b1;
          wb_data_q <= '0;
        end
`endif
        RESP: begin
          wb_err_q  <= 1'b0;
          wb_data_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // bus_req is decoded from the state register. Its asynchronous reset
  // therefore drops the request as soon as rst rises.
  assign ex_ready      = ex_ready_q;
  assign wb_valid      = (state == RESP);
  assign wb_data       = wb_data_q;
  assign wb_err        = wb_err_q;
  assign bus.bus_req   = (state == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Drives load_store_unit with directed and random loads and stores. A bus
//   responder acks each request after a chosen number of wait cycles. A monitor
//   compares the bus and writeback outputs, on every cycle, against a
//   behavioural model of the access rules.
//   The timeout cases are compiled in only when LSU_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int DW       = 32;
  localparam int MAX_WAIT = 16;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] data;
    int          req_cycles;  // cycles bus_req must be high
    int          lat;         // cycles from accept edge to wb_valid cycle
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [DW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic          wb_err;

  load_store_unit_if #(.DATA_WIDTH(DW)) bus ();

  load_store_unit #(.DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_err    (wb_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  exp_t        cur_e;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_rdata = '0;
  int          cur_delay = 0;
  logic        cur_active = 1'b0;
  logic        done = 1'b0;
  int          req_cnt = 0;
  logic [31:0] last_data = '0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_be = '0;
  logic        last_err = 1'b0;
  logic        last_we = 1'b0;
  int          last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model, written as access rules rather than hardware:
  // - an access covers bytes [off, off+size)
  // - store bytes repeat every `size` lanes
  // - a load takes the covered bytes and extends them to 32 bits.
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int delay);
    exp_t        e;
    int          size;
    int          off;
    int          bits;
    logic        legal;
    logic [31:0] v;
    logic [31:0] mask;
    size = 1 << f3[1:0];
    off  = int'(a % 4);
    if (rd && wr)  legal = 1'b0;
    else if (rd)   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else           legal = (f3 <= 3'd2);
    if (legal && (off % size) != 0) legal = 1'b0;
    e.err = !legal;
    e.we = wr;
    e.be = '0;
    e.wrep = '0;
    e.data = '0;
    e.req_cycles = 0;
    e.lat = 0;
    if (legal) begin
      for (int i = 0; i < 4; i++) begin
        e.be[i] = (i >= off) && (i < off + size);
        e.wrep[8*i +: 8] = wd[8*(i % size) +: 8];
      end
      if (rd) begin
        v = rdata >> (8 * off);
        if (size < 4) begin
          bits = 8 * size;
          mask = (32'd1 << bits) - 32'd1;
          v = v & mask;
          if (!f3[2] && v[bits-1]) v = v | ~mask;
        end
        e.data = v;
      end
      if (TO_EN && delay >= MAX_WAIT) begin
        e.err = 1'b1;
        e.data = '0;
        e.req_cycles = MAX_WAIT;
        e.lat = MAX_WAIT;
      end else begin
        e.req_cycles = delay + 1;
        e.lat = delay + 1;
      end
    end
    return e;
  endfunction

  // Bus responder: acks after cur_delay wait cycles. Outside a request it
  // drives random acks, which the unit must ignore.
  always @(negedge clk) begin
    if (bus.bus_req && cur_active && (cyc - acc_cyc) == cur_delay) begin
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = cur_rdata;
    end else if (bus.bus_req) begin
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = $urandom;
    end else begin
      bus.bus_ack   = ($urandom_range(0, 3) == 0);
      bus.bus_rdata = $urandom;
    end
  end

  // Compare process: on every cycle, bus_req and wb_valid must match the
  // model's timeline. Bus fields and writeback fields are compared whenever
  // they are qualified.
  always @(negedge clk) begin : monitor
    int   rel;
    logic exp_req;
    logic exp_wb;
    rel     = cyc - acc_cyc;
    exp_req = cur_active && (rel >= 0) && (rel < cur_e.req_cycles);
    exp_wb  = cur_active && (rel == cur_e.lat);
    check("bus_req", bus.bus_req, exp_req);
    if (bus.bus_req) req_cnt++;
    if (bus.bus_req && exp_req) begin
      check("bus_we", bus.bus_we, cur_e.we);
      check("bus_addr", bus.bus_addr, cur_addr & 32'hFFFF_FFFC);
      check("bus_be", bus.bus_be, cur_e.be);
      if (cur_e.we) check("bus_wdata", bus.bus_wdata, cur_e.wrep);
      last_addr  = bus.bus_addr;
      last_be    = bus.bus_be;
      last_we    = bus.bus_we;
      last_wdata = bus.bus_wdata;
    end
    check("wb_valid", wb_valid, exp_wb);
    if (wb_valid && exp_wb) begin
      check("wb_data", wb_data, cur_e.data);
      check("wb_err", wb_err, cur_e.err);
      last_data  = wb_data;
      last_err   = wb_err;
      last_lat   = rel;
      cur_active = 1'b0;
      done       = 1'b1;
    end
  end

  // Called #1 after a rising edge. Waits (bounded) for ex_ready, then presents
  // one operation for exactly one edge.
  task automatic issue_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay);
    int n;
    n = 0;
    while (ex_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ex_ready_idle", ex_ready, 1'b1);
    cur_e     = model(rd, wr, f3, a, wd, rdata, delay);
    cur_addr  = a;
    cur_rdata = rdata;
    cur_delay = delay;
    done      = 1'b0;
    req_cnt   = 0;
    ex_valid  = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    cur_active = rd | wr;
    ex_valid   = 1'b0;
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    wdata      = $urandom;
    check("ex_ready_after_accept", ex_ready, !(rd | wr));
  endtask

  task automatic wait_op(input int delay);
    int n;
    int budget;
    n = 0;
    budget = ((delay > MAX_WAIT) ? MAX_WAIT : delay) + 10;
    while (!done && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("completion_seen", done, 1'b1);
    cur_active = 1'b0;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdata, input int delay);
    issue_op(rd, wr, f3, a, wd, rdata, delay);
    if (rd | wr) wait_op(delay);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (%0d/%0d checks passed so far)", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stimulus
    int          a1;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    int          sz;

    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ex_ready", ex_ready, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_err", wb_err, 1'b0);
    check("rst_bus_req", bus.bus_req, 1'b0);
    check("rst_bus_we", bus.bus_we, 1'b0);
    check("rst_bus_addr", bus.bus_addr, 32'h0);
    check("rst_bus_be", bus.bus_be, 4'h0);
    check("rst_bus_wdata", bus.bus_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("ready_low_at_release", ex_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_release", ex_ready, 1'b1);

    // LW with two wait cycles.
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
    check("lw_data", last_data, 32'hDEAD_BEEF);
    check("lw_be", last_be, 4'b1111);
    check("lw_addr", last_addr, 32'h100);
    check("lw_err", last_err, 1'b0);
    check("lw_latency", last_lat, 3);

    // Byte and halfword extraction.
    do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lb_data", last_data, 32'hFFFF_FF80);
    check("lb_be", last_be, 4'b1000);
    check("lb_latency", last_lat, 1);
    do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1);
    check("lbu_data", last_data, 32'h0000_0080);
    do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 0);
    check("lhu_data", last_data, 32'h0000_80FF);
    check("lhu_be", last_be, 4'b1100);

    // Halfword store.
    do_op(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 32'h5555_5555, 1);
    check("sh_we", last_we, 1'b1);
    check("sh_be", last_be, 4'b1100);
    check("sh_wdata", last_wdata, 32'hABCD_ABCD);
    check("sh_wb_data", last_data, 32'h0);
    check("sh_err", last_err, 1'b0);

    // Misaligned accesses: no bus request, error pulse right after accept.
    do_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    a1 = acc_cyc;
    check("mis_lw_err", last_err, 1'b1);
    check("mis_lw_latency", last_lat, 0);
    check("mis_lw_no_req", req_cnt, 0);
    check("mis_lw_ready_back", ex_ready, 1'b1);
    do_op(1'b0, 1'b1, 3'b001, 32'h3, 32'hFFFF_FFFF, 32'h0, 0);
    check("mis_sh_err", last_err, 1'b1);
    check("mis_sh_no_req", req_cnt, 0);
    check("err_back_to_back_spacing", acc_cyc - a1, 2);

    // ex_valid without read or write is ignored.
    do_op(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_ready", ex_ready, 1'b1);

    // Reset while a request is outstanding.
    issue_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h1234_5678, 1000);
    repeat (3) @(posedge clk);
    #1;
    check("req_before_rst", bus.bus_req, 1'b1);
    cur_active = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_drops_req_async", bus.bus_req, 1'b0);
    check("rst_no_wb_valid", wb_valid, 1'b0);
    check("rst_clears_ready", ex_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("ready_low_at_rerelease", ex_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_rerelease", ex_ready, 1'b1);
    do_op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h0BAD_F00D, 1);
    check("lw_after_rst_data", last_data, 32'h0BAD_F00D);

`ifdef LSU_TIMEOUT_EN
    // No ack at all: request held for exactly MAX_WAIT cycles, then error.
    do_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h1111_1111, 1000);
    check("to_req_cycles", req_cnt, MAX_WAIT);
    check("to_err", last_err, 1'b1);
    check("to_data", last_data, 32'h0);
    // Ack on the last allowed cycle completes normally.
    do_op(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'hCAFE_F00D, MAX_WAIT - 1);
    check("to_edge_req_cycles", req_cnt, MAX_WAIT);
    check("to_edge_err", last_err, 1'b0);
    check("to_edge_data", last_data, 32'hCAFE_F00D);
`endif

    // Random traffic, mostly legal and mostly aligned.
    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 19);
      rd = (r < 10) || (r == 18);
      wr = (r >= 10 && r < 18) || (r == 18);
      if ($urandom_range(0, 4) == 0) begin
        f3 = 3'($urandom);
      end else if (rd) begin
        r  = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      a  = $urandom;
      sz = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
      do_op(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the execute ALU.
- Consumes the ALU result as the effective address, together with store data and funct3 from the execute stage.
- Runs a req/ack transaction on the data-memory bus and returns aligned, sign/zero-extended load data to writeback.
- Handles byte, halfword and word accesses; misaligned or illegal accesses are reported as errors instead of being issued.

Parameters:
DATA_WIDTH, 32, width of address, store data and load data (the byte/half/word rules below are fixed at 32)
MAX_WAIT, 16, bus cycles allowed in REQ before timeout (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
ex_valid  input  1  execute stage presents an operation
ex_ready  output  1  unit can accept an operation
mem_read  input  1  operation is a load
mem_write  input  1  operation is a store
funct3  input  3  access size/sign (RISC-V funct3)
addr  input  DATA_WIDTH  effective address (ALU result)
wdata  input  DATA_WIDTH  store data (rs2)
wb_valid  output  1  one-cycle completion pulse
wb_data  output  DATA_WIDTH  extended load data; 0 for stores and errors
wb_err  output  1  misaligned, illegal or timed-out access; valid with wb_valid
bus_req  output  1  bus request
bus_we  output  1  bus write
bus_addr  output  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  DATA_WIDTH  lane-replicated store data
bus_ack  input  1  bus completion
bus_rdata  input  DATA_WIDTH  bus read word, valid with bus_ack

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. While rst is high, bus_req drops asynchronously.
- ex_ready is registered: reset 0, set on the first clock edge after rst deasserts, cleared on accept, set again on the edge entering IDLE.
- States: IDLE, REQ, RESP.
- Accept: ex_valid & ex_ready & (mem_read | mem_write) at a clock edge. Latch addr, wdata, funct3 and op.
- ex_valid with neither mem_read nor mem_write is ignored: no wb_valid.
- Error check at accept; error causes IDLE->RESP directly, with no bus activity:
  - mem_read and mem_write both high.
  - Load funct3 not in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Store funct3 not in {000 SB, 001 SH, 010 SW}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- Legal access: IDLE->REQ. In REQ:
  - bus_req=1, with bus_we, bus_addr, bus_be and bus_wdata held stable until the ack cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- REQ->RESP on the edge where bus_ack=1. The load word is extracted from bus_rdata by offset, sign-extended (LB/LH) or zero-extended (LBU/LHU), and registered.
- RESP lasts one cycle:
  - wb_valid=1.
  - wb_err and wb_data are valid (wb_data=0 on store or error).
  - Then RESP->IDLE.
- Latency: accept at edge T, bus_req high from T+1, ack sampled at edge T+1+k, wb_valid high during the following cycle.
  - Zero-wait ack (k=0): wb_valid in cycle T+2.
  - Error path: wb_valid in cycle T+1.
- bus_ack outside REQ is ignored.
- Back-to-back: the next accept is possible on the edge ending RESP->IDLE+1 (ex_ready returns on entry to IDLE).
- rst mid-transaction: the operation is abandoned with no wb_valid; the bus master must tolerate a dropped req.

Optional Feature:
- Macro LSU_TIMEOUT_EN, when defined:
  - A counter runs in REQ and is cleared on entry to REQ.
  - If MAX_WAIT cycles elapse without bus_ack: bus_req drops, go to RESP with wb_err=1, wb_data=0.
  - An ack arriving on the same edge as expiry wins: normal completion.
- Without the macro: no counter, and REQ waits indefinitely.

Test Plan:
- LW addr=0x100, bus ack 2 cycles later with rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, wb_valid one cycle after ack, wb_data=0xDEADBEEF, wb_err=0.
- LB addr=0x103, rdata=0x80FF0000 -> bus_be=1000, wb_data=0xFFFFFF80; repeat as LBU -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
- SH addr=0x206, wdata=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, wb_valid with wb_data=0, wb_err=0.
- LW addr=0x101, then SH addr=0x3 -> no bus_req, wb_valid next cycle with wb_err=1, each taking two cycles total.
- rst asserted while in REQ -> bus_req falls immediately, no wb_valid; after release, ex_ready=1 one edge later and the next LW completes normally.
- LSU_TIMEOUT_EN with MAX_WAIT=16, no ack -> bus_req high exactly 16 cycles, then wb_valid with wb_err=1; ack on the 16th cycle -> normal data, wb_err=0.
